receiver: RTL and testbench
===========================

# receiver

GMII receive path. Deframes incoming Ethernet frames on `gmii_rx_clk` and checks FCS and length. Writes each accepted frame into the RX frame slot memory in the same slot layout the transmit path consumes. Frames are committed atomically by advancing `mem_wr_ptr`. Dropped frames never become visible to the slot reader.

## Interface
- `MAGIC`, 16'h5555, value written to header word 0 of every committed frame
- `MIN_LEN`, 16'd60, minimum accepted frame length in bytes, FCS excluded
- `MAX_LEN`, 16'd1514, maximum accepted frame length in bytes, FCS excluded
- `sys_rst` input 1: asynchronous, active-high reset
- `gmii_rx_clk` input 1: receive clock; all logic runs on it
- `global_counter` input 64: free-running timestamp source, already synchronous to `gmii_rx_clk`
- `gmii_rxd` input 8: receive data
- `gmii_rx_dv` input 1: receive data valid
- `gmii_rx_er` input 1: receive error
- `slot_rx_eth_data` output 16: write data; first wire byte in [15:8]
- `slot_rx_eth_byte_en` output 2: byte enables; [1] = [15:8], [0] = [7:0]
- `slot_rx_eth_addr` output 14: word write address
- `slot_rx_eth_wr_en` output 1: write strobe, one word per asserted cycle
- `mem_rd_ptr` input 14: consumer read pointer, in words
- `mem_wr_ptr` output 14: commit pointer, in words
- `rx_drop_cnt` output 16: saturating count of dropped frames

## Operation
- Slot layout, word offsets from `base` (base = `mem_wr_ptr` at SFD):
  - 0: `MAGIC`
  - 1: frame_len (bytes, FCS excluded)
  - 2..5: SFD timestamp, bits [63:48] down to [15:0]
  - 6..7: received FCS, bits [31:16] then [15:0], taken exactly as it appeared on the wire
  - 8 onward: frame bytes, two per word, big-endian
- All pointer and address arithmetic is modulo 2^14.
- Committed slot size is 8 + ceil(frame_len/2) words. FCS bytes are also written past that point; they are not committed and get overwritten by the next frame.
- `free` = `mem_rd_ptr` − `mem_wr_ptr` − 1. One word always stays unused, so full ≠ empty.
- States:
  - **IDLE**: dv=1 with rxd=0x55 → PRE. dv=1 with any other byte → DROP.
  - **PRE**: 0x55 stays in PRE. 0xD5 captures `global_counter`, latches base, clears the CRC, and goes to DATA, or to DROP if `free` < 767. Any other byte, or er=1, → DROP. dv=0 → IDLE, no count.
  - **DATA**: every byte updates CRC-32 (IEEE 802.3) and the byte counter. On each even-indexed byte, hold it. On each odd-indexed byte, write {held, rxd} with byte_en=11 at base+8+index/2. er=1 → DROP. Byte count > `MAX_LEN`+4 → DROP. dv=0 → FLUSH.
  - **FLUSH**: if a held byte is pending, write {held, 8'h00} with byte_en=10. Then evaluate the frame:
    - frame_len = count − 4
    - drop if frame_len < `MIN_LEN`
    - drop if the CRC residue ≠ 32'hC704DD7B (see Configuration)
    - pass → HDR; fail → IDLE and increment `rx_drop_cnt`
  - **HDR**: 8 cycles writing header words 0..7 in order, byte_en=11. Then `mem_wr_ptr` ← base + 8 + ceil(frame_len/2). Then IDLE.
  - **DROP**: wait for dv=0, increment `rx_drop_cnt` once, then IDLE. Nothing is committed.
- A new preamble that arrives during FLUSH or HDR is ignored; that frame goes through DROP without being counted. A 12-byte IFG makes this impossible in practice.
- `rx_drop_cnt` saturates at 16'hFFFF.

## Timing
- Inputs are sampled on `gmii_rx_clk` posedge.
- A data write strobe is asserted the cycle after its odd byte is sampled.
- The timestamp is the `global_counter` value on the cycle the SFD is sampled.
- Commit latency from the first cycle with dv=0:
  - FLUSH: 1 cycle
  - HDR: 8 cycles
  - `mem_wr_ptr` updates on the 10th cycle
- Throughput: back-to-back frames with the minimum 12-byte IFG must all be accepted.
- Reset:
  - All outputs reset to 0: `slot_rx_eth_*`, `mem_wr_ptr`, `rx_drop_cnt`.
  - State goes to IDLE immediately, asynchronously.
  - A frame in flight is lost and is not counted.
  - After reset is released, reception restarts at the next preamble. The DROP state absorbs any partial frame still on the wire.

## Configuration
- `RX_FCS_CHECK_EN`:
  - Defined: the CRC residue check is applied in FLUSH; mismatch → drop.
  - Undefined: no CRC logic is instantiated. Header words 6..7 still hold the last 4 received bytes. Only the length and error checks drop frames.

## Test plan
- 64-byte good frame (60 + FCS), 7×0x55 + 0xD5 preamble, `global_counter`=64'h0123456789ABCDEF at SFD → words base..base+7 = 5555, 003C, 0123, 4567, 89AB, CDEF, FCS hi, FCS lo; `mem_wr_ptr` += 38 on the 10th cycle after dv falls.
- 65-byte frame (61 + FCS), odd length → the last data word is written with byte_en=10 via FLUSH only if the byte count is odd; `mem_wr_ptr` += 39.
- Good frame with one payload bit flipped, `RX_FCS_CHECK_EN` defined → no commit, `rx_drop_cnt`=1. Same stimulus with the macro undefined → commit.
- `gmii_rx_er` pulsed mid-payload, then a 1514-byte frame followed by a 1515-byte frame → two drops, `mem_wr_ptr` advances only for the 1514-byte frame (by 765).
- `mem_rd_ptr` = `mem_wr_ptr` + 700 → frame dropped at SFD. Then `mem_wr_ptr` = 14'h3FF0 with an empty buffer → the header and data addresses wrap through 0, and the commit value is (3FF0 + 38) mod 2^14 = 14'h0016.
- Assert `sys_rst` during the DATA state → all outputs 0 at once; the remainder of the frame is absorbed; the next good frame is committed at base 0.

Source files
------------

// File: rtl/receiver_if.sv
// ---------------------------------------------------------------------------
// receiver_if : RX frame slot memory write bus.
//
// One 16-bit word is written per cycle in which slot_rx_eth_wr_en is high.
//   slot_rx_eth_data     16  write data, first wire byte in [15:8]
//   slot_rx_eth_byte_en   2  byte enables, [1] -> [15:8], [0] -> [7:0]
//   slot_rx_eth_addr     14  word address
//   slot_rx_eth_wr_en     1  write strobe
// The master modport is the writer (receiver); slave is the slot memory.
// ---------------------------------------------------------------------------
interface receiver_if;
    logic [15:0] slot_rx_eth_data;
    logic [1:0]  slot_rx_eth_byte_en;
    logic [13:0] slot_rx_eth_addr;
    logic        slot_rx_eth_wr_en;

    modport master (
        output slot_rx_eth_data,
        output slot_rx_eth_byte_en,
        output slot_rx_eth_addr,
        output slot_rx_eth_wr_en
    );

    modport slave (
        input slot_rx_eth_data,
        input slot_rx_eth_byte_en,
        input slot_rx_eth_addr,
        input slot_rx_eth_wr_en
    );
endinterface

// File: rtl/receiver.sv
// ---------------------------------------------------------------------------
// receiver : GMII receive path.
//
// Deframes Ethernet frames on gmii_rx_clk, checks length (and optionally
// FCS), and writes each frame into the RX slot memory as an 8-word header
// followed by the frame bytes. A frame becomes visible only when mem_wr_ptr
// is advanced past it; dropped frames never move mem_wr_ptr.
//
// Ports:
//   gmii_rx_clk     receive clock, all logic runs on it
//   sys_rst         asynchronous active-high reset
//   global_counter  64-bit timestamp source (synchronous to gmii_rx_clk)
//   gmii_rxd/_dv/_er GMII receive inputs
//   slot            receiver_if.master, slot memory write bus
//   mem_rd_ptr      consumer read pointer (words)
//   mem_wr_ptr      commit pointer (words)
//   rx_drop_cnt     saturating dropped-frame count
//
// Build option: define RX_FCS_CHECK_EN to enable the CRC-32 residue check.
// Without it no CRC logic exists and only length/error checks drop frames.
// ---------------------------------------------------------------------------
module receiver #(
    parameter logic [15:0] MAGIC   = 16'h5555,
    parameter logic [15:0] MIN_LEN = 16'd60,
    parameter logic [15:0] MAX_LEN = 16'd1514
) (
    input  logic        gmii_rx_clk,
    input  logic        sys_rst,
    input  logic [63:0] global_counter,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    receiver_if.master  slot,
    input  logic [13:0] mem_rd_ptr,
    output logic [13:0] mem_wr_ptr,
    output logic [15:0] rx_drop_cnt
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_HDR   = 3'd4;
    localparam logic [2:0] S_DROP  = 3'd5;

    // Largest possible frame (1514 + FCS) occupies 8 + 759 words.
    localparam logic [13:0] FREE_MIN = 14'd767;

    logic [2:0]  state;
    logic [15:0] byte_cnt;
    logic [2:0]  hdr_idx;
    logic        drop_cnt_en;
    logic        dv_q;

    logic [63:0] ts;
    logic [13:0] base;
    logic [31:0] last4;
    logic [15:0] frame_len;

    logic [13:0] free;
    logic        sfd_hit;
    logic        data_byte;
    logic [15:0] cnt_nxt;
    logic [13:0] data_addr;
    logic [13:0] len_words;
    logic [15:0] hdr_word;
    logic        fcs_ok;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign free      = mem_rd_ptr - mem_wr_ptr - 14'd1;
    assign sfd_hit   = (state == S_PRE) && gmii_rx_dv && !gmii_rx_er && (gmii_rxd == 8'hD5);
    assign data_byte = (state == S_DATA) && gmii_rx_dv && !gmii_rx_er;
    assign cnt_nxt   = byte_cnt + 16'd1;
    // Word holding byte index byte_cnt (odd byte) or pending byte count-1 (flush).
    assign data_addr = base + 14'd8 + byte_cnt[14:1];
    assign len_words = frame_len[14:1] + {13'd0, frame_len[0]};

    always_comb begin
        hdr_word = MAGIC;
        case (hdr_idx)
            3'd0:    hdr_word = MAGIC;
            3'd1:    hdr_word = frame_len;
            3'd2:    hdr_word = ts[63:48];
            3'd3:    hdr_word = ts[47:32];
            3'd4:    hdr_word = ts[31:16];
            3'd5:    hdr_word = ts[15:0];
            3'd6:    hdr_word = last4[31:16];
            default: hdr_word = last4[15:0];
        endcase
    end

`ifdef RX_FCS_CHECK_EN
    // MSB-first register fed LSB-first per byte; equals the bit-reversed
    // form of the usual reflected CRC, so the good-frame residue is C704DD7B.
    logic [31:0] crc;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge gmii_rx_clk) begin
        if (sfd_hit)        crc <= 32'hFFFFFFFF;
        else if (data_byte) crc <= crc_step(crc, gmii_rxd);
    end

    assign fcs_ok = (crc == 32'hC704DD7B);
`else
    assign fcs_ok = 1'b1;
`endif

    // Frame data captures; no reset needed, qualified by the FSM strobes.
    always_ff @(posedge gmii_rx_clk) begin
        if (sfd_hit) begin
            ts   <= global_counter;
            base <= mem_wr_ptr;
        end
        // last4[7:0] doubles as the held even byte; last4 ends as the FCS.
        if (data_byte) last4 <= {last4[23:0], gmii_rxd};
        if (state == S_FLUSH) frame_len <= byte_cnt - 16'd4;
    end

    always_ff @(posedge gmii_rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state                    <= S_IDLE;
            byte_cnt                 <= 16'd0;
            hdr_idx                  <= 3'd0;
            drop_cnt_en              <= 1'b0;
            // Assume the line is mid-frame until dv has been seen low.
            dv_q                     <= 1'b1;
            mem_wr_ptr               <= 14'd0;
            rx_drop_cnt              <= 16'd0;
            slot.slot_rx_eth_data    <= 16'd0;
            slot.slot_rx_eth_byte_en <= 2'b00;
            slot.slot_rx_eth_addr    <= 14'd0;
            slot.slot_rx_eth_wr_en   <= 1'b0;
        end else begin
            dv_q                   <= gmii_rx_dv;
            slot.slot_rx_eth_wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gmii_rx_dv) begin
                        // dv already high last cycle: a frame we missed the start of.
                        if (dv_q) begin
                            state       <= S_DROP;
                            drop_cnt_en <= 1'b0;
                        end else if (gmii_rxd == 8'h55) begin
                            state <= S_PRE;
                        end else begin
                            state       <= S_DROP;
                            drop_cnt_en <= 1'b1;
                        end
                    end
                end
                S_PRE: begin
                    if (!gmii_rx_dv) begin
                        state <= S_IDLE;
                    end else if (gmii_rx_er) begin
                        state       <= S_DROP;
                        drop_cnt_en <= 1'b1;
                    end else if (gmii_rxd == 8'hD5) begin
                        byte_cnt <= 16'd0;
                        if (free < FREE_MIN) begin
                            state       <= S_DROP;
                            drop_cnt_en <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end else if (gmii_rxd != 8'h55) begin
                        state       <= S_DROP;
                        drop_cnt_en <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (!gmii_rx_dv) begin
                        state <= S_FLUSH;
                    end else if (gmii_rx_er || (cnt_nxt > (MAX_LEN + 16'd4))) begin
                        state       <= S_DROP;
                        drop_cnt_en <= 1'b1;
                    end else begin
                        byte_cnt <= cnt_nxt;
                        if (byte_cnt[0]) begin
                            slot.slot_rx_eth_wr_en   <= 1'b1;
                            slot.slot_rx_eth_data    <= {last4[7:0], gmii_rxd};
                            slot.slot_rx_eth_byte_en <= 2'b11;
                            slot.slot_rx_eth_addr    <= data_addr;
                        end
                    end
                end
                S_FLUSH: begin
                    if (byte_cnt[0]) begin
                        slot.slot_rx_eth_wr_en   <= 1'b1;
                        slot.slot_rx_eth_data    <= {last4[7:0], 8'h00};
                        slot.slot_rx_eth_byte_en <= 2'b10;
                        slot.slot_rx_eth_addr    <= data_addr;
                    end
                    if ((byte_cnt >= (MIN_LEN + 16'd4)) && fcs_ok) begin
                        state   <= S_HDR;
                        hdr_idx <= 3'd0;
                    end else begin
                        state       <= S_IDLE;
                        rx_drop_cnt <= sat_inc(rx_drop_cnt);
                    end
                end
                S_HDR: begin
                    slot.slot_rx_eth_wr_en   <= 1'b1;
                    slot.slot_rx_eth_data    <= hdr_word;
                    slot.slot_rx_eth_byte_en <= 2'b11;
                    slot.slot_rx_eth_addr    <= base + {11'd0, hdr_idx};
                    hdr_idx                  <= hdr_idx + 3'd1;
                    if (hdr_idx == 3'd7) begin
                        mem_wr_ptr <= base + 14'd8 + len_words;
                        state      <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (!gmii_rx_dv) begin
                        if (drop_cnt_en) rx_drop_cnt <= sat_inc(rx_drop_cnt);
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_receiver.sv
// ---------------------------------------------------------------------------
// tb_receiver : directed bench for receiver.
//
// Frames are built with a reflected CRC-32 FCS. When a frame is sent, the
// bench decides whether it must commit; committed frames push their
// expected header and data words onto a scoreboard, which is popped and
// compared against a shadow of the slot memory whenever mem_wr_ptr moves.
// ---------------------------------------------------------------------------
module tb_receiver;
`ifdef RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    logic        gmii_rx_clk = 1'b0;
    logic        sys_rst;
    logic [63:0] global_counter;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [13:0] mem_rd_ptr;
    logic [13:0] mem_wr_ptr;
    logic [15:0] rx_drop_cnt;

    receiver_if slot();

    receiver dut (
        .gmii_rx_clk    (gmii_rx_clk),
        .sys_rst        (sys_rst),
        .global_counter (global_counter),
        .gmii_rxd       (gmii_rxd),
        .gmii_rx_dv     (gmii_rx_dv),
        .gmii_rx_er     (gmii_rx_er),
        .slot           (slot),
        .mem_rd_ptr     (mem_rd_ptr),
        .mem_wr_ptr     (mem_wr_ptr),
        .rx_drop_cnt    (rx_drop_cnt)
    );

    always #4 gmii_rx_clk = ~gmii_rx_clk;

    typedef struct packed {
        logic [13:0]  base;
        logic [13:0]  next;
        logic [127:0] hdr;
        logic [31:0]  nwords;
    } commit_t;

    commit_t     sb[$];
    logic [15:0] exp_words[$];
    logic [15:0] tbmem [0:16383];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          commit_cyc = 0;
    int          dv_fall_cyc = 0;
    logic [13:0] prev_wr = 14'd0;
    logic [13:0] exp_wr  = 14'd0;
    logic [15:0] exp_drop = 16'd0;
    logic        flush_seen = 1'b0;
    logic [13:0] flush_addr = 14'd0;
    logic [15:0] flush_data = 16'd0;
    logic [7:0]  last_byte  = 8'd0;
    logic [13:0] last_base  = 14'd0;

    always @(posedge gmii_rx_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slot memory shadow and commit scoreboard.
    initial begin
        forever begin
            @(negedge gmii_rx_clk);
            if (sys_rst) begin
                prev_wr = 14'd0;
            end else begin
                if (slot.slot_rx_eth_wr_en) begin
                    if (slot.slot_rx_eth_byte_en[1])
                        tbmem[slot.slot_rx_eth_addr][15:8] = slot.slot_rx_eth_data[15:8];
                    if (slot.slot_rx_eth_byte_en[0])
                        tbmem[slot.slot_rx_eth_addr][7:0] = slot.slot_rx_eth_data[7:0];
                    if (slot.slot_rx_eth_byte_en == 2'b10) begin
                        flush_seen = 1'b1;
                        flush_addr = slot.slot_rx_eth_addr;
                        flush_data = slot.slot_rx_eth_data;
                    end
                end
                if (mem_wr_ptr !== prev_wr) begin
                    commit_cyc = cyc;
                    if (sb.size() == 0) begin
                        check("commit_unexpected", mem_wr_ptr, prev_wr);
                    end else begin
                        commit_t e;
                        int bad;
                        logic [13:0] a;
                        logic [15:0] ew;
                        e = sb.pop_front();
                        check("commit_ptr", mem_wr_ptr, e.next);
                        for (int k = 0; k < 8; k++) begin
                            a = e.base + 14'(k);
                            check($sformatf("hdr_word%0d", k), tbmem[a], e.hdr[127-16*k -: 16]);
                        end
                        bad = 0;
                        for (int w = 0; w < int'(e.nwords); w++) begin
                            ew = exp_words.pop_front();
                            a = e.base + 14'd8 + 14'(w);
                            if (tbmem[a] !== ew) bad++;
                        end
                        check("data_words_bad", bad, 0);
                    end
                    prev_wr = mem_wr_ptr;
                end
            end
        end
    end

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(negedge gmii_rx_clk);
        gmii_rx_dv     = dv;
        gmii_rxd       = d;
        gmii_rx_er     = er;
        global_counter = global_counter + 64'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    // len = bytes excluding FCS; er_at < 0 means no error pulse.
    task automatic send_frame(input int len, input bit corrupt, input int er_at,
                              input bit set_ts, input logic [63:0] ts_val);
        logic [7:0]  b[$];
        logic [31:0] c;
        logic [13:0] free;
        logic [63:0] ts;
        bit          commit;
        commit_t     e;
        int          nw;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            b.push_back(8'($urandom));
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        b.push_back(c[7:0]);
        b.push_back(c[15:8]);
        b.push_back(c[23:16]);
        b.push_back(c[31:24]);
        if (corrupt) b[10] = b[10] ^ 8'h04;
        last_byte = b[b.size()-1];
        last_base = exp_wr;

        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        @(negedge gmii_rx_clk);
        gmii_rx_dv = 1'b1;
        gmii_rxd   = 8'hD5;
        gmii_rx_er = 1'b0;
        global_counter = set_ts ? ts_val : global_counter + 64'd1;
        ts = global_counter;

        free   = mem_rd_ptr - exp_wr - 14'd1;
        commit = (free >= 14'd767) && (er_at < 0) && (len >= 60) && (len <= 1514)
                 && !(corrupt && FCS_EN);
        if (commit) begin
            nw       = (len + 1) / 2;
            e.base   = exp_wr;
            e.nwords = 32'(nw);
            e.next   = exp_wr + 14'd8 + 14'(nw);
            e.hdr    = {16'h5555, 16'(len), ts, b[len], b[len+1], b[len+2], b[len+3]};
            for (int k = 0; k < nw; k++) exp_words.push_back({b[2*k], b[2*k+1]});
            sb.push_back(e);
            exp_wr = e.next;
        end else begin
            exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 16'd1;
        end

        for (int i = 0; i < b.size(); i++) drive(1'b1, b[i], (i == er_at));
        drive(1'b0, 8'h00, 1'b0);
        dv_fall_cyc = cyc;
        idle(11);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_wr_ptr"}, mem_wr_ptr, exp_wr);
        check({tag, "_drop_cnt"}, rx_drop_cnt, exp_drop);
        check({tag, "_sb_pending"}, sb.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_ptr"}, mem_wr_ptr, 0);
        check({tag, "_drop_cnt"}, rx_drop_cnt, 0);
        check({tag, "_data"}, slot.slot_rx_eth_data, 0);
        check({tag, "_byte_en"}, slot.slot_rx_eth_byte_en, 0);
        check({tag, "_addr"}, slot.slot_rx_eth_addr, 0);
        check({tag, "_wr_en"}, slot.slot_rx_eth_wr_en, 0);
    endtask

    initial begin
        logic [13:0] dd;
        int          d_left;
        int          sz;

        sys_rst        = 1'b1;
        global_counter = 64'd0;
        gmii_rxd       = 8'h00;
        gmii_rx_dv     = 1'b0;
        gmii_rx_er     = 1'b0;
        mem_rd_ptr     = 14'd0;
        idle(3);
        check_outputs_zero("reset");
        sys_rst = 1'b0;
        idle(4);

        // 64-byte good frame with a known timestamp; commit lands 10 cycles after dv falls.
        flush_seen = 1'b0;
        send_frame(60, 1'b0, -1, 1'b1, 64'h0123456789ABCDEF);
        checkpoint("good64");
        check("good64_commit_latency", commit_cyc - dv_fall_cyc, 10);
        check("good64_no_flush_write", flush_seen, 1'b0);
        check("good64_ptr_38", mem_wr_ptr, 14'd38);

        // 65-byte frame: odd byte count leaves the last FCS byte for the flush word.
        flush_seen = 1'b0;
        send_frame(61, 1'b0, -1, 1'b0, 64'd0);
        checkpoint("odd65");
        check("odd65_flush_seen", flush_seen, 1'b1);
        check("odd65_flush_addr", flush_addr, last_base + 14'd8 + 14'd32);
        check("odd65_flush_data", flush_data, {last_byte, 8'h00});
        check("odd65_ptr", mem_wr_ptr, last_base + 14'd39);

        // Payload bit flipped after the FCS was computed.
        send_frame(60, 1'b1, -1, 1'b0, 64'd0);
        checkpoint("bitflip");

        // Error mid-payload, then the longest legal frame, then one byte too long.
        send_frame(100, 1'b0, 30, 1'b0, 64'd0);
        checkpoint("rx_er");
        send_frame(1514, 1'b0, -1, 1'b0, 64'd0);
        checkpoint("len1514");
        check("len1514_advance", mem_wr_ptr - last_base, 14'd765);
        send_frame(1515, 1'b0, -1, 1'b0, 64'd0);
        checkpoint("len1515");

        // Not enough room at SFD.
        mem_rd_ptr = exp_wr + 14'd700;
        send_frame(60, 1'b0, -1, 1'b0, 64'd0);
        checkpoint("no_room");

        // Advance the commit pointer to 3FF0 with an always-empty buffer.
        dd     = 14'h3FF0 - exp_wr;
        d_left = int'(dd);
        while (d_left > 0) begin
            mem_rd_ptr = exp_wr;
            if (d_left >= 803)      sz = 765;
            else if (d_left <= 765) sz = d_left;
            else                    sz = 38;
            send_frame(2 * (sz - 8), 1'b0, -1, 1'b0, 64'd0);
            d_left -= sz;
        end
        checkpoint("fill");
        check("fill_at_3ff0", mem_wr_ptr, 14'h3FF0);
        mem_rd_ptr = exp_wr;
        send_frame(60, 1'b0, -1, 1'b0, 64'd0);
        checkpoint("wrap");
        check("wrap_commit_0016", mem_wr_ptr, 14'h0016);

        // Reset in the middle of DATA; the rest of the frame must be absorbed silently.
        mem_rd_ptr = exp_wr;
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 1'b0);
        #1;
        sys_rst = 1'b1;
        sb.delete();
        exp_words.delete();
        exp_wr   = 14'd0;
        exp_drop = 16'd0;
        #1;
        check_outputs_zero("midframe_reset");
        for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 1'b0);
        sys_rst = 1'b0;
        for (int i = 0; i < 30; i++) drive(1'b1, 8'($urandom), 1'b0);
        idle(12);
        checkpoint("after_reset");
        mem_rd_ptr = 14'd0;
        send_frame(60, 1'b0, -1, 1'b0, 64'd0);
        checkpoint("post_reset_frame");
        check("post_reset_base0", mem_wr_ptr, 14'd38);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
